parity_push_stage: RTL
======================

// Module: parity_push_stage
// PURPOSE
//  Upstream feeder for the parity FIFO push port. Accepts raw DATA_WIDTH-bit words on a valid/ready
//  input and appends one parity bit. Drives a (DATA_WIDTH+1)-bit word into push_data/push_valid,
//  honouring push_grant. A 2-entry skid buffer gives full throughput with fully registered outputs.
// PARAMETERS
//  DATA_WIDTH  32  raw payload width; output word is DATA_WIDTH+1 bits
//  EVEN_ODD    0   0: even parity (total ones incl. parity bit even); 1: odd parity
//  PARITY_BIT  0   0: parity at bit 0, payload at [DATA_WIDTH:1]; 1: parity at bit DATA_WIDTH, payload at [DATA_WIDTH-1:0]
//  CNT_WIDTH   16  width of transfer counter
// PORTS
//  clk           in   1             single clock, all state on posedge
//  rst           in   1             synchronous, active-high reset
//  in_data_i     in   DATA_WIDTH    raw payload
//  in_valid_i    in   1             payload valid
//  in_ready_o    out  1             stage can accept; registered
//  err_inject_i  in   1             sampled with accepted word; used only under PARITY_PUSH_INJECT_EN
//  push_data_o   out  DATA_WIDTH+1  to FIFO push_data_i
//  push_valid_o  out  1             to FIFO push_valid_i
//  push_grant_i  in   1             from FIFO push_grant_o
//  sent_count_o  out  CNT_WIDTH     number of completed FIFO pushes
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out/skid valid=0, push_data_o=0, push_valid_o=0, in_ready_o=1, sent_count_o=0.
//    Reset mid-transfer drops both buffered words. No partial state survives.
//  - Accept = in_valid_i & in_ready_o. Transfer = push_valid_o & push_grant_i. Both are evaluated at the same posedge.
//  - Parity is computed combinationally on in_data_i at accept: p = ^in_data_i ^ EVEN_ODD. The word is stored pre-formatted.
//  - Registers: OUT (drives push_*_o), SKID. in_ready_o = ~SKID.valid, registered.
//  - States, by occupancy:
//      EMPTY: OUT and SKID both empty.
//      ONE:   OUT full, SKID empty.
//      TWO:   OUT and SKID both full.
//  - EMPTY: accept -> ONE. The word appears on push_*_o at the next cycle, so latency is 1 cycle.
//  - ONE:
//      transfer & accept -> ONE, with the new word loaded into OUT.
//      transfer only -> EMPTY.
//      accept only -> TWO, with the new word into SKID.
//      neither -> hold.
//  - TWO (in_ready_o=0, no accept possible): transfer -> ONE, with SKID moved to OUT. Otherwise hold.
//  - push_data_o/push_valid_o are stable while push_valid_o=1 and push_grant_i=0. No deassert without a transfer.
//  - Order is strictly FIFO: SKID always drains to OUT before any newer word.
//  - push_grant_i with push_valid_o=0 is ignored.
//  - sent_count_o increments by 1 per transfer and wraps from 2^CNT_WIDTH-1 to 0.
//  - Sustained accept+transfer gives 1 word/cycle.
// CONFIGURATION
//  PARITY_PUSH_INJECT_EN defined:
//    - an accepted word with err_inject_i=1 gets its parity bit inverted (payload unchanged).
//    - this exercises the downstream parity-drop path.
//  Not defined:
//    - err_inject_i is ignored; parity is always correct.
//    - no inversion logic is synthesised.
// TESTING (DATA_WIDTH=32, EVEN_ODD=0, PARITY_BIT=0)
//  1. rst=1 for 2 cycles with in_valid_i=1 -> push_valid_o=0, in_ready_o=1, sent_count_o=0; nothing accepted.
//  2. in 0x00000003, grant=1 -> next cycle push_data_o=0x0_00000006, push_valid_o=1; in 0x00000001 -> push_data_o=0x0_00000003.
//  3. grant=0, push 0xA, 0xB -> in_ready_o=0 after 2nd accept, 3rd word held off;
//     grant=1 -> 0xA then 0xB out on consecutive cycles; push_data_o stable while stalled.
//  4. valid=1 and grant=1 for 100 cycles, data 1..100 -> 100 consecutive transfers in order; sent_count_o=100.
//  5. Preload CNT to wrap: with CNT_WIDTH=4, 17 transfers -> sent_count_o=1.
//  6. With PARITY_PUSH_INJECT_EN: in 0x00000003, err_inject_i=1 -> push_data_o=0x0_00000007;
//     without the macro -> 0x0_00000006.

Source files
------------

// File: rtl/parity_push_stage.sv
// rtl/parity_push_stage.sv - parity-appending 2-entry skid stage feeding the parity FIFO push port
// Optional feature macro: PARITY_PUSH_INJECT_EN (err_inject_i inverts the parity bit of an accepted word)
module parity_push_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int EVEN_ODD   = 0,
   parameter int PARITY_BIT = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  err_inject_i,
   output logic [DATA_WIDTH:0]   push_data_o,
   output logic                  push_valid_o,
   input  logic                  push_grant_i,
   output logic [CNT_WIDTH-1:0]  sent_count_o
);

   // Occupancy: EMPTY = nothing held, ONE = OUT full, TWO = OUT and SKID full
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic PAR_SENSE = (EVEN_ODD != 0);

   state_t              state;
   logic [DATA_WIDTH:0] skid_data;
   logic [DATA_WIDTH:0] in_word;
   logic                parity;
   logic                accept;
   logic                xfer;

   assign accept = in_valid_i & in_ready_o;
   assign xfer   = push_valid_o & push_grant_i;

`ifndef PARITY_PUSH_INJECT_EN
   logic unused_err_inject;
   assign unused_err_inject = err_inject_i;
`endif

   // Format the incoming word: compute parity and place it at the configured end
   always_comb begin
      parity = (^in_data_i) ^ PAR_SENSE;
`ifdef PARITY_PUSH_INJECT_EN
      parity = parity ^ err_inject_i;
`endif
      if (PARITY_BIT == 0) begin
         in_word = {in_data_i, parity};
      end else begin
         in_word = {parity, in_data_i};
      end
   end

   // Skid-buffer FSM: moves words IN -> OUT/SKID -> push port, all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_EMPTY;
         push_data_o  <= '0;
         push_valid_o <= 1'b0;
         skid_data    <= '0;
         in_ready_o   <= 1'b1;
         sent_count_o <= '0;
      end else begin
         if (xfer) begin
            sent_count_o <= sent_count_o + CNT_WIDTH'(1);
         end
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  push_data_o  <= in_word;
                  push_valid_o <= 1'b1;
                  state        <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (xfer && accept) begin
                  push_data_o <= in_word;
               end else if (xfer) begin
                  push_valid_o <= 1'b0;
                  state        <= ST_EMPTY;
               end else if (accept) begin
                  skid_data  <= in_word;
                  in_ready_o <= 1'b0;
                  state      <= ST_TWO;
               end
            end
            ST_TWO: begin
               if (xfer) begin
                  push_data_o <= skid_data;
                  in_ready_o  <= 1'b1;
                  state       <= ST_ONE;
               end
            end
            default: begin
               state        <= ST_EMPTY;
               push_valid_o <= 1'b0;
               in_ready_o   <= 1'b1;
            end
         endcase
      end
   end

endmodule
